// File: rtl/hilo_pkg.sv
// hilo_pkg: shared types and constants for the HI/LO unit.
package hilo_pkg;
  localparam int DATA_W = 32;
  localparam int WDOG_W = 6;
  localparam int WDOG_LIMIT = 40;
  typedef enum logic [1:0] {IDLE, MULT_RUN, DIV_RUN, RELEASE} state_e;
endpackage

// File: rtl/op_watchdog.sv
// op_watchdog: counts RUN cycles and flags the cycle on which the limit is reached.
module op_watchdog
  import hilo_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  logic [WDOG_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear_i ? '0 : enable_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  // high during the 40th RUN cycle, so the count reaches the limit on that edge
  assign expired_o = enable_i && cnt_q == WDOG_W'(WDOG_LIMIT - 1);
endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register file with multiply/divide sequencing FSM and watchdog.
module hilo_unit
  import hilo_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start_mult,
  input  logic              start_div,
  input  logic              finalMult,
  input  logic              finalDiv,
  input  logic              div_by_zero,
  input  logic [DATA_W-1:0] mult_hi,
  input  logic [DATA_W-1:0] mult_lo,
  input  logic [DATA_W-1:0] div_hi,
  input  logic [DATA_W-1:0] div_lo,
  input  logic              write_hi,
  input  logic              write_lo,
  input  logic [DATA_W-1:0] wdata,
  output logic              multControl,
  output logic              divControl,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              busy,
  output logic              done,
  output logic              div_zero_exc,
  output logic              timeout
);
  state_e state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic done_q, done_d, exc_q, exc_d, to_q, to_d, expired;
  op_watchdog u_wdog (
    .clk_i    (clock),
    .rst_ni   (reset),
    .clear_i  (state_q == IDLE),
    .enable_i (state_q == MULT_RUN || state_q == DIV_RUN),
    .expired_o(expired)
  );
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    exc_d   = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = start_mult ? MULT_RUN : start_div ? DIV_RUN : IDLE;
        hi_d    = write_hi ? wdata : hi_q;
        lo_d    = write_lo ? wdata : lo_q;
      end
      MULT_RUN: begin
        state_d = (finalMult || expired) ? RELEASE : MULT_RUN;
        hi_d    = finalMult ? mult_hi : hi_q;
        lo_d    = finalMult ? mult_lo : lo_q;
        done_d  = finalMult;
        to_d    = !finalMult && expired;
      end
      DIV_RUN: begin
        state_d = (finalDiv || expired) ? RELEASE : DIV_RUN;
        hi_d    = (finalDiv && !div_by_zero) ? div_hi : hi_q;
        lo_d    = (finalDiv && !div_by_zero) ? div_lo : lo_q;
        done_d  = finalDiv;
        exc_d   = finalDiv && div_by_zero;
        to_d    = !finalDiv && expired;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      exc_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
      to_q    <= to_d;
    end
  end
  assign multControl  = state_q == MULT_RUN;
  assign divControl   = state_q == DIV_RUN;
  assign busy         = state_q != IDLE;
  assign hi_out       = hi_q;
  assign lo_out       = lo_q;
  assign done         = done_q;
  assign div_zero_exc = exc_q;
  assign timeout      = to_q;
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: table-driven vectors with a result scoreboard for hilo_unit.
module tb_hilo_unit;
  logic clock = 1'b0, reset = 1'b1;
  logic start_mult = 0, start_div = 0, finalMult = 0, finalDiv = 0, div_by_zero = 0;
  logic [31:0] mult_hi = 0, mult_lo = 0, div_hi = 0, div_lo = 0, wdata = 0;
  logic write_hi = 0, write_lo = 0;
  logic multControl, divControl, busy, done, div_zero_exc, timeout;
  logic [31:0] hi_out, lo_out;
  int checks = 0, errors = 0;

  typedef struct {
    bit is_div, both, noise, fin_en, dz;
    int lat;
    logic [31:0] rhi, rlo, ehi, elo;
    bit eexc, eto;
  } vec_t;
  typedef struct {logic [31:0] hi, lo; bit exc, to;} exp_t;
  exp_t sbq[$];
  vec_t tv[8];

  hilo_unit dut (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .finalMult(finalMult), .finalDiv(finalDiv), .div_by_zero(div_by_zero),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
    .write_hi(write_hi), .write_lo(write_lo), .wdata(wdata),
    .multControl(multControl), .divControl(divControl), .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .done(done), .div_zero_exc(div_zero_exc), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset && (done || timeout)) begin
      if (sbq.size() == 0) chk("sb_unexpected", {done, timeout}, 2'b00);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_flags", {done, div_zero_exc, timeout}, {!e.to, e.exc, e.to});
        chk("sb_hi", hi_out, e.hi);
        chk("sb_lo", lo_out, e.lo);
      end
    end
  end

  task automatic run(input vec_t v);
    int n;
    bit got, fin;
    sbq.push_back('{v.ehi, v.elo, v.eexc, v.eto});
    start_mult = !v.is_div || v.both;
    start_div  = v.is_div || v.both;
    tick();
    start_mult = 0;
    start_div  = 0;
    chk("ctl_rise", {busy, multControl, divControl}, v.is_div ? 3'b101 : 3'b110);
    mult_hi = v.rhi; mult_lo = v.rlo; div_hi = v.rhi; div_lo = v.rlo;
    n = 0;
    got = 0;
    while (!got && n < 60) begin
      fin = v.fin_en && n == v.lat;
      finalMult   = fin && !v.is_div;
      finalDiv    = fin && v.is_div;
      div_by_zero = fin && v.dz;
      if (v.noise && n == 0) begin
        start_mult = 1; start_div = 1; write_hi = 1; write_lo = 1; wdata = 32'hDEADBEEF;
        if (v.is_div) finalMult = 1;
        else finalDiv = 1;
      end
      tick();
      n++;
      {finalMult, finalDiv, div_by_zero, start_mult, start_div, write_hi, write_lo} = '0;
      got = done || timeout;
    end
    chk("latency", n, v.fin_en ? v.lat + 1 : 40);
    chk("release", {busy, multControl, divControl}, 3'b100);
    tick();
    chk("idle", {busy, done, timeout, div_zero_exc}, 4'b0);
  endtask

  initial begin
    tv[0] = '{0, 0, 0, 1, 0, 32, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0};
    tv[1] = '{1, 0, 0, 1, 0, 4, 32'd2, 32'd14, 32'd2, 32'd14, 0, 0};
    tv[2] = '{0, 1, 1, 1, 0, 0, 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 0, 0};
    tv[3] = '{1, 0, 1, 1, 1, 2, 32'hAAAA, 32'hBBBB, 32'h12345678, 32'h9ABCDEF0, 1, 0};
    tv[4] = '{0, 0, 1, 0, 0, 0, 32'h1, 32'h2, 32'h12345678, 32'h9ABCDEF0, 0, 1};
    tv[5] = '{1, 0, 0, 0, 0, 0, 32'h3, 32'h4, 32'h12345678, 32'h9ABCDEF0, 0, 1};
    tv[6] = '{1, 0, 0, 1, 0, 39, 32'd5, 32'd6, 32'd5, 32'd6, 0, 0};
    tv[7] = '{0, 0, 0, 1, 0, 38, 32'h80000000, 32'h1, 32'h80000000, 32'h1, 0, 0};
    #1 reset = 0;
    #2;
    chk("reset_state", {hi_out, lo_out, busy, done, div_zero_exc, timeout, multControl, divControl}, '0);
    tick();
    tick();
    reset = 1;
    tick();
    for (int i = 0; i < 8; i++) run(tv[i]);
    write_hi = 1; wdata = 32'h1234;
    tick();
    write_hi = 0;
    chk("write_hi", {hi_out, lo_out}, {32'h1234, 32'h1});
    run('{1, 0, 0, 1, 1, 3, 32'h5, 32'h6, 32'h1234, 32'h1, 1, 0});
    write_hi = 1; write_lo = 1; wdata = 32'hCAFEF00D;
    tick();
    write_hi = 0; write_lo = 0;
    chk("write_both", {hi_out, lo_out}, {32'hCAFEF00D, 32'hCAFEF00D});
    start_mult = 1;
    tick();
    start_mult = 0;
    mult_hi = 32'hBAD0; mult_lo = 32'hBAD1;
    tick(); tick(); tick();
    #2 reset = 0;
    #1;
    chk("async_reset", {hi_out, lo_out, busy, done, div_zero_exc, timeout, multControl, divControl}, '0);
    tick();
    reset = 1;
    tick();
    chk("post_reset_idle", {busy, multControl}, 2'b00);
    run('{0, 0, 0, 1, 0, 5, 32'h11, 32'h22, 32'h11, 32'h22, 0, 0});
    chk("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
